// File: rtl/switch_event_gen_if.sv
// Switch-event bus: debounced level in, single-cycle event pulses and held flag out.
// The master drives the switch level; the event generator is the slave.
interface switch_event_gen_if;
    logic i_switch;
    logic o_press;
    logic o_release;
    logic o_short;
    logic o_long;
    logic o_repeat;
    logic o_held;

    modport master (
        output i_switch,
        input  o_press, o_release, o_short, o_long, o_repeat, o_held
    );

    modport slave (
        input  i_switch,
        output o_press, o_release, o_short, o_long, o_repeat, o_held
    );
endinterface

// File: rtl/switch_event_gen.sv
// Turns a debounced switch level into registered press/release/short/long/repeat
// pulses plus a held flag, all on clk with one cycle of latency.
//
// state     | meaning
// IDLE      | switch released, hold counter parked at 0
// PRESSED   | held for fewer than c_LONG_LIMIT samples, counting down to long
// LONG_HELD | long press reported, counting down to each auto-repeat
module switch_event_gen #(
    parameter int c_LONG_LIMIT   = 25000000,
    parameter int c_REPEAT_LIMIT = 5000000,
    parameter int c_CNT_W        = 25
) (
    input  logic               clk,
    input  logic               i_rst,
    switch_event_gen_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, PRESSED, LONG_HELD} state_t;

    // Down-counter holds the samples remaining until the next event; a value
    // of 1 on a high sample is the terminal count.
    localparam logic [c_CNT_W-1:0] LONG_LOAD = c_CNT_W'(c_LONG_LIMIT - 1);
    localparam logic [c_CNT_W-1:0] REP_LOAD  = c_CNT_W'(c_REPEAT_LIMIT);
    localparam logic [c_CNT_W-1:0] CNT_ONE   = c_CNT_W'(1);
    localparam bit                 REP_EN    = (c_REPEAT_LIMIT > 0);

    state_t             state_q, state_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic               press_q, press_d;
    logic               release_q, release_d;
    logic               short_q, short_d;
    logic               long_q, long_d;
    logic               repeat_q, repeat_d;
    logic               held_q, held_d;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            short_q   <= short_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        held_d    = held_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.i_switch) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                    held_d  = 1'b1;
                    cnt_d   = LONG_LOAD;
                end
            end
            PRESSED: begin
                // A release on the would-be long sample still counts as short.
                if (!bus.i_switch) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    short_d   = 1'b1;
                    held_d    = 1'b0;
                    cnt_d     = '0;
                end else if (cnt_q == CNT_ONE) begin
                    state_d = LONG_HELD;
                    long_d  = 1'b1;
                    cnt_d   = REP_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            LONG_HELD: begin
                if (!bus.i_switch) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    held_d    = 1'b0;
                    cnt_d     = '0;
                end else if (REP_EN) begin
                    if (cnt_q == CNT_ONE) begin
                        repeat_d = 1'b1;
                        cnt_d    = REP_LOAD;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                held_d  = 1'b0;
            end
        endcase
    end

    assign bus.o_press   = press_q;
    assign bus.o_release = release_q;
    assign bus.o_short   = short_q;
    assign bus.o_long    = long_q;
    assign bus.o_repeat  = repeat_q;
    assign bus.o_held    = held_q;

endmodule

// File: tb/tb_switch_event_gen.sv
// Self-checking bench for switch_event_gen: table of switch samples with expected
// pulse vectors through a scoreboard queue, plus reset and repeat-disabled sequences.
module tb_switch_event_gen;

    localparam int TB_L = 8;
    localparam int TB_R = 4;

    logic clk;
    logic i_rst;

    switch_event_gen_if bus();
    switch_event_gen_if bus_nr();

    switch_event_gen #(.c_LONG_LIMIT(TB_L), .c_REPEAT_LIMIT(TB_R), .c_CNT_W(4)) u_dut (
        .clk   (clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    switch_event_gen #(.c_LONG_LIMIT(TB_L), .c_REPEAT_LIMIT(0), .c_CNT_W(4)) u_dut_nr (
        .clk   (clk),
        .i_rst (i_rst),
        .bus   (bus_nr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector layout: {press, release, short, long, repeat, held}
    typedef struct {
        logic       sw;
        logic [5:0] exp;
    } vec_t;

    vec_t       tbl[$];
    logic [5:0] sb[$];
    int         n_pass  = 0;
    int         n_total = 0;

    function automatic logic [5:0] outs_main();
        return {bus.o_press, bus.o_release, bus.o_short, bus.o_long, bus.o_repeat, bus.o_held};
    endfunction

    function automatic logic [5:0] outs_nr();
        return {bus_nr.o_press, bus_nr.o_release, bus_nr.o_short, bus_nr.o_long,
                bus_nr.o_repeat, bus_nr.o_held};
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        else
            n_pass++;
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) tbl.push_back('{1'b0, 6'b000000});
    endtask

    // n high samples followed by one low (release) sample.
    task automatic add_hold(input int n);
        logic [5:0] e;
        for (int k = 1; k <= n; k++) begin
            e = {(k == 1), 1'b0, 1'b0, (k == TB_L),
                 (TB_R > 0 && k > TB_L && ((k - TB_L) % TB_R) == 0), 1'b1};
            tbl.push_back('{1'b1, e});
        end
        e = {1'b0, 1'b1, (n < TB_L), 1'b0, 1'b0, 1'b0};
        tbl.push_back('{1'b0, e});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] e;
        int         long_at;
        int         n_long;
        int         n_rep;
        int         long_k;

        i_rst           = 1'b1;
        bus.i_switch    = 1'b0;
        bus_nr.i_switch = 1'b0;

        add_idle(2);
        add_hold(5);
        add_idle(2);
        add_hold(17);
        add_idle(2);
        add_hold(7);
        add_idle(1);
        add_hold(8);
        add_idle(1);
        add_hold(3);
        add_hold(3);
        add_idle(2);

        repeat (2) @(posedge clk);
        #1;
        check("reset_main", int'(outs_main()), 0);
        check("reset_norep", int'(outs_nr()), 0);
        @(negedge clk);
        i_rst = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            bus.i_switch = tbl[i].sw;
            sb.push_back(tbl[i].exp);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check($sformatf("vec%0d", i), int'(outs_main()), int'(e));
        end

        // Repeat disabled: 30-sample hold gives one long, no repeats, plain release.
        n_long = 0;
        n_rep  = 0;
        long_k = 0;
        @(negedge clk);
        bus_nr.i_switch = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (bus_nr.o_long) begin
                n_long++;
                long_k = k;
            end
            if (bus_nr.o_repeat) n_rep++;
        end
        check("norep_long_count", n_long, 1);
        check("norep_long_k", long_k, TB_L);
        check("norep_repeat_count", n_rep, 0);
        check("norep_held", int'(bus_nr.o_held), 1);
        @(negedge clk);
        bus_nr.i_switch = 1'b0;
        @(posedge clk);
        #1;
        check("norep_release", int'(outs_nr()), int'(6'b010000));

        // Reset mid-hold at k = 10, switch still high when reset releases.
        @(negedge clk);
        bus.i_switch = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
        end
        check("held_before_rst", int'(bus.o_held), 1);
        #2;
        i_rst = 1'b1;
        #1;
        check("async_rst_clears", int'(outs_main()), 0);
        @(negedge clk);
        @(negedge clk);
        i_rst = 1'b0;
        @(posedge clk);
        #1;
        check("press_after_rst", int'(outs_main()), int'(6'b100001));
        long_at = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.o_long) begin
                long_at = c;
                break;
            end
        end
        check("long_after_rst_delay", long_at, TB_L - 1);
        @(negedge clk);
        bus.i_switch = 1'b0;
        @(posedge clk);
        #1;
        check("release_after_rst_long", int'(outs_main()), int'(6'b010000));
        @(posedge clk);
        #1;
        check("idle_after_release", int'(outs_main()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
